uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter one frame at a time. It hands each byte over
// with a single-cycle start pulse and flags a transmitter that never goes busy.
module uart_tx_feeder #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int START_TO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              flush,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic              start_err,
  input  logic              clr_err,
  output logic [1:0]        dbg_state
);

  // Write side: a byte moves when wr_valid && wr_ready in the same cycle (and no flush).
  // wr_ready is driven from registered state only, so it never depends on wr_valid.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = (START_TO > 1) ? $clog2(START_TO + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              overflow_q, overflow_d;
  logic              start_err_q, start_err_d;
  logic [7:0]        mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic timeout;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign wr_ready = !full && !rst;
  assign push     = wr_valid && wr_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timer_d    = timer_q;
    pop        = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && tx_ready) state_d = LOAD;
      end
      LOAD: begin
        // A flush in the IDLE->LOAD cycle can leave nothing to pop.
        if (count_q != '0) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = WAIT_BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle beats clr_err.
  always_comb begin
    overflow_d  = overflow_q;
    start_err_d = start_err_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      start_err_d = 1'b0;
    end
    if (wr_valid && full) overflow_d  = 1'b1;
    if (timeout)          start_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      overflow_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      overflow_q  <= overflow_d;
      start_err_q <= start_err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign count     = count_q;
  assign busy      = (count_q != '0) || (state_q != IDLE);
  assign overflow  = overflow_q;
  assign start_err = start_err_q;
  assign dbg_state = state_q;

endmodule
